// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect input and
// decode-side valid/ready output. master = fetch unit, slave = environment.
interface instruction_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        fetch_err;

   modport master (
      output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fetch_err,
      input  imem_ack, imem_data, redirect_valid, redirect_pc, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fetch_err,
      output imem_ack, imem_data, redirect_valid, redirect_pc, dec_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues one outstanding word fetch at a
// time and buffers returned words in a 2-entry FIFO towards decode. Redirects
// flush the FIFO; a request already in flight is drained and its data dropped.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned redirect sets a
// sticky fetch_err and halts fetching until reset).
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input logic                      clock,
   input logic                      reset,
   instruction_fetch_unit_if.master bus
);

`ifdef IFETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;
`else
   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] stale_q, stale_d;

   logic [31:0] fifo_instr [2];
   logic [31:0] fifo_pc    [2];
   logic        rd_q, wr_q;
   logic [1:0]  occ_q;
   logic [1:0]  occ_after;

   logic        push, pop, slot_free;
   logic [31:0] redir_target;
   logic        halt_pending;

`ifdef IFETCH_ALIGN_CHECK_EN
   logic        err_q;
   logic        redir_bad;

   assign redir_target = bus.redirect_pc;
   assign redir_bad    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
   assign halt_pending = err_q || redir_bad;
   assign bus.fetch_err = err_q;
`else
   logic        unused_align_bits;

   // Low target bits are dropped so every redirect lands on a word boundary.
   assign redir_target      = {bus.redirect_pc[31:2], 2'b00};
   assign unused_align_bits = ^bus.redirect_pc[1:0];
   assign halt_pending      = 1'b0;
   assign bus.fetch_err     = 1'b0;
`endif

   // FIFO bookkeeping; a push only happens for a live (non-redirected) ack.
   assign pop       = bus.dec_valid && bus.dec_ready;
   assign push      = (state_q == REQ) && bus.imem_ack && !bus.redirect_valid;
   assign occ_after = occ_q + {1'b0, push} - {1'b0, pop};
   assign slot_free = (occ_after < 2'd2);

   // Outputs: DRAIN keeps presenting the abandoned address until its ack.
   assign bus.imem_req  = (state_q == REQ) || (state_q == DRAIN);
   assign bus.imem_addr = (state_q == DRAIN) ? stale_q : pc_q;
   assign bus.dec_valid = (occ_q != 2'd0);
   assign bus.dec_instr = fifo_instr[rd_q];
   assign bus.dec_pc    = fifo_pc[rd_q];

   // State, PC and stale-address registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         stale_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stale_q <= stale_d;
      end
   end

   // Next-state and PC selection; redirect overrides the normal fetch flow.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stale_d = stale_q;

      case (state_q)
         IDLE: begin
            if (slot_free && !halt_pending) state_d = REQ;
         end
         REQ: begin
            if (bus.imem_ack) begin
               pc_d    = pc_q + PC_STEP;
               state_d = slot_free ? REQ : IDLE;
            end
         end
         DRAIN: begin
            if (bus.imem_ack) state_d = IDLE;
         end
         default: state_d = state_q;
      endcase

      if (bus.redirect_valid) begin
         pc_d = redir_target;
         if (state_q == REQ) begin
            if (bus.imem_ack) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
               stale_d = pc_q;
            end
         end else if (state_q == IDLE) begin
            state_d = IDLE;
         end
      end

`ifdef IFETCH_ALIGN_CHECK_EN
      // Any path that would go back to IDLE parks in HALT once an error is seen.
      if (halt_pending && (state_d == IDLE)) state_d = HALT;
`endif
   end

   // 2-entry FIFO storage and pointers; a redirect empties it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         occ_q <= '0;
      end else if (bus.redirect_valid) begin
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         occ_q <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_q] <= bus.imem_data;
            fifo_pc[wr_q]    <= pc_q;
            wr_q             <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         occ_q <= occ_after;
      end
   end

`ifdef IFETCH_ALIGN_CHECK_EN
   // Sticky misaligned-redirect flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (redir_bad) begin
         err_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic clock = 1'b0;
   logic reset;

   int checks = 0;
   int errors = 0;
   int xfers  = 0;
   int mem_lat = 0;
   int wait_cnt = 0;

   exp_t        sb[$];
   logic [31:0] ack_log[$];

   instruction_fetch_unit_if bus();

   instruction_fetch_unit #(
      .RESET_PC(32'h0000_0000),
      .PC_STEP (32'd4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0800_0004;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [31:0] start);
      exp_t e;
      sb.delete();
      for (int i = 0; i < 64; i++) begin
         e.pc    = start + 32'(4 * i);
         e.instr = mem_word(e.pc);
         sb.push_back(e);
      end
   endtask

   // One bench cycle at the negedge: drive ready/redirect, score any decode
   // transfer that the coming posedge will complete, then answer the memory.
   task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
      exp_t e;
      @(negedge clock);
      bus.dec_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      if (bus.dec_valid && rdy) begin
         xfers++;
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("dec_pc", bus.dec_pc, e.pc);
            check("dec_instr", bus.dec_instr, e.instr);
         end
      end
      if (rv) begin
`ifdef IFETCH_ALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) sb.delete();
         else fill(rpc);
`else
         fill({rpc[31:2], 2'b00});
`endif
      end
      if (bus.imem_req) begin
         if (wait_cnt >= mem_lat) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = mem_word(bus.imem_addr);
            ack_log.push_back(bus.imem_addr);
            wait_cnt = 0;
         end else begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = 32'hDEAD_BEEF;
            wait_cnt++;
         end
      end else begin
         bus.imem_ack = 1'b0;
         wait_cnt     = 0;
      end
   endtask

   initial begin
      int base;
      reset              = 1'b1;
      bus.imem_ack       = 1'b0;
      bus.imem_data      = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.dec_ready      = 1'b0;

      // Reset values
      @(negedge clock);
      @(negedge clock);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_valid", 32'(bus.dec_valid), 32'd0);
      check("rst_instr", bus.dec_instr, 32'h0);
      check("rst_pc", bus.dec_pc, 32'h0);
      check("rst_err", 32'(bus.fetch_err), 32'd0);

      // Zero-latency streaming from reset
      fill(32'h0);
      ack_log.delete();
      reset = 1'b0;
      xfers = 0;
      cycle(1, 0, 0);
      check("first_req", 32'(bus.imem_req), 32'd1);
      check("first_addr", bus.imem_addr, 32'h0);
      cycle(1, 0, 0);
      check("lat1_valid", 32'(bus.dec_valid), 32'd1);
      check("lat1_instr", bus.dec_instr, 32'h0800_0004);
      check("lat1_pc", bus.dec_pc, 32'h0);
      repeat (7) cycle(1, 0, 0);
      check("throughput", 32'(xfers), 32'd8);
      check("addr_seq0", ack_log[0], 32'h0);
      check("addr_seq1", ack_log[1], 32'h4);
      check("addr_seq2", ack_log[2], 32'h8);

      // Decode stall: FIFO fills to 2 and requests stop
      base = ack_log.size();
      repeat (5) cycle(0, 0, 0);
      check("stall_acks", 32'(ack_log.size() - base), 32'd1);
      check("stall_req", 32'(bus.imem_req), 32'd0);
      check("stall_valid", 32'(bus.dec_valid), 32'd1);
      repeat (6) cycle(1, 0, 0);

      // Known state: redirect to 0x100 with decode stalled
      cycle(0, 1, 32'h100);
      cycle(0, 0, 0);
      check("redir_valid_low", 32'(bus.dec_valid), 32'd0);
      repeat (6) cycle(0, 0, 0);
      check("full_req", 32'(bus.imem_req), 32'd0);
      check("full_head_pc", bus.dec_pc, 32'h100);

      // 3-cycle memory, redirect to 0x10 in the 2nd wait cycle of fetch 0x108
      mem_lat = 3;
      ack_log.delete();
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      cycle(1, 1, 32'h10);
      cycle(1, 0, 0);
      check("drain_req", 32'(bus.imem_req), 32'd1);
      check("drain_addr", bus.imem_addr, 32'h108);
      check("drain_valid", 32'(bus.dec_valid), 32'd0);
      repeat (6) cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("post_drain_valid", 32'(bus.dec_valid), 32'd1);
      check("post_drain_pc", bus.dec_pc, 32'h10);
      check("drain_ack0", ack_log[0], 32'h108);
      check("drain_ack1", ack_log[1], 32'h10);

      // Redirect to 0x3C coinciding with the ack for address 8
      mem_lat = 0;
      repeat (3) cycle(1, 0, 0);
      cycle(1, 1, 32'h0);
      ack_log.delete();
      repeat (3) cycle(1, 0, 0);
      cycle(1, 1, 32'h3C);
      check("coinc_acks", 32'(ack_log.size()), 32'd3);
      check("coinc_addr", ack_log[2], 32'h8);
      cycle(1, 0, 0);
      check("coinc_v1", 32'(bus.dec_valid), 32'd0);
      cycle(1, 0, 0);
      check("coinc_v2", 32'(bus.dec_valid), 32'd0);
      cycle(1, 0, 0);
      check("coinc_v3", 32'(bus.dec_valid), 32'd1);
      check("coinc_pc0", bus.dec_pc, 32'h3C);
      cycle(1, 0, 0);
      check("coinc_pc1", bus.dec_pc, 32'h40);

      // PC wrap at the top of the address space
      cycle(1, 1, 32'hFFFF_FFF8);
      ack_log.delete();
      repeat (6) cycle(1, 0, 0);
      check("wrap_cnt", 32'(ack_log.size() >= 4), 32'd1);
      check("wrap_a0", ack_log[0], 32'hFFFF_FFF8);
      check("wrap_a1", ack_log[1], 32'hFFFF_FFFC);
      check("wrap_a2", ack_log[2], 32'h0);
      check("wrap_a3", ack_log[3], 32'h4);

      // Misaligned redirect
      cycle(1, 1, 32'h22);
      ack_log.delete();
      repeat (6) cycle(1, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
      check("mis_err", 32'(bus.fetch_err), 32'd1);
      check("mis_valid", 32'(bus.dec_valid), 32'd0);
      check("mis_req", 32'(bus.imem_req), 32'd0);
      check("mis_acks", 32'(ack_log.size()), 32'd0);
      cycle(1, 1, 32'h40);
      repeat (3) cycle(1, 0, 0);
      check("halt_req", 32'(bus.imem_req), 32'd0);
      check("halt_err", 32'(bus.fetch_err), 32'd1);
`else
      check("mis_err", 32'(bus.fetch_err), 32'd0);
      check("mis_addr", ack_log[0], 32'h20);
      mem_lat = 3;
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("pre_reset_req", 32'(bus.imem_req), 32'd1);
`endif

      // Asynchronous reset in the middle of a cycle
      #2 reset = 1'b1;
      #1;
      check("async_req", 32'(bus.imem_req), 32'd0);
      check("async_addr", bus.imem_addr, 32'h0);
      check("async_valid", 32'(bus.dec_valid), 32'd0);
      check("async_err", 32'(bus.fetch_err), 32'd0);
      @(negedge clock);
      mem_lat      = 3;
      wait_cnt     = 0;
      bus.imem_ack = 1'b0;
      ack_log.delete();
      fill(32'h0);
      reset = 1'b0;
      cycle(1, 0, 0);
      check("rerun_req", 32'(bus.imem_req), 32'd1);
      check("rerun_addr", bus.imem_addr, 32'h0);
      repeat (3) cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("rerun_ack", ack_log[0], 32'h0);
      check("rerun_valid", 32'(bus.dec_valid), 32'd1);
      check("rerun_pc", bus.dec_pc, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch initiator driving the instruction memory's word-read port. It owns the program counter and issues word-aligned byte addresses (PC steps by 4) with a req/ack handshake, holding at most one request outstanding. Returned words are buffered in a 2-entry FIFO and presented to decode with valid/ready. Branch/jump redirects flush the FIFO and discard any stale in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `PC_STEP`, default 4: byte increment between sequential fetches.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  byte address of the requested word; stable while `imem_req` is high.
- `imem_ack`  in  1  response valid; may assert in the same cycle as `imem_req` (zero-latency memory).
- `imem_data`  in  32  instruction word; sampled only when `imem_req && imem_ack`.
- `redirect_valid`  in  1  one-cycle branch/jump redirect.
- `redirect_pc`  in  32  redirect target.
- `dec_valid`  out  1  FIFO head valid.
- `dec_ready`  in  1  decode accepts head.
- `dec_instr`  out  32  head instruction.
- `dec_pc`  out  32  address the head instruction was fetched from.
- `fetch_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- FSM states: IDLE (no request outstanding), REQ (request outstanding), DRAIN (stale request outstanding after redirect), HALT (error, only with macro).
- IDLE -> REQ when `occupancy + 0 < 2` and not HALT; `imem_addr` = PC.
- REQ, ack: push {PC, `imem_data`} into FIFO, PC += `PC_STEP`; stay in REQ if free slot remains after push/pop, else IDLE.
- Free-slot check counts the same-cycle pop (`dec_valid && dec_ready`).
- Redirect (highest priority, any state): FIFO flushed, PC <= `redirect_pc`.
  - If REQ with no ack this cycle -> DRAIN; `imem_req` stays high at the old address.
  - If ack arrives in the same cycle as the redirect, the data is discarded -> IDLE.
- DRAIN: on ack, discard data -> IDLE. A further redirect in DRAIN updates PC only.
- FIFO: 2 entries; simultaneous push and pop allowed at any occupancy; never pushes when full.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 without error.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `fetch_err`=0; FSM=IDLE; FIFO empty.
- First request is asserted in the first cycle after reset deassertion.
- Fetch-to-decode latency is 1 cycle: ack at edge N, `dec_valid`=1 after edge N.
- With zero-latency ack and `dec_ready` held at 1, throughput is 1 instruction/cycle.
- `dec_valid` is 0 in the cycle after a redirect. First redirected instruction:
  - no DRAIN: `dec_valid` rises 2 cycles after the redirect edge;
  - DRAIN: 2 cycles after the stale ack.
- Reset mid-request drops `imem_req` asynchronously; the memory must tolerate an abandoned request.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - a redirect with `redirect_pc[1:0] != 0` sets `fetch_err`=1 (sticky until reset) and flushes the FIFO;
  - after any outstanding request drains, FSM enters HALT and issues no further requests.
- Not defined: `redirect_pc[1:0]` is forced to 2'b00, `fetch_err` is tied 0, and HALT does not exist.

## Test plan
- Reset release with a zero-latency memory holding 32'h0800_0004 at 0, `dec_ready`=1 -> `imem_addr` sequence 0, 4, 8…; `dec_instr`=32'h0800_0004, `dec_pc`=0 one cycle after the first ack.
- `dec_ready`=0 for 5 cycles -> exactly 2 words buffered, `imem_req`=0; on ready release, words are delivered in order at PC 0 then 4 with no loss or duplication.
- Memory with 3-cycle ack latency, redirect to 32'h10 in the 2nd wait cycle -> `imem_addr` stays at the old address until ack; stale word is never presented; next request is at 32'h10; first `dec_pc`=32'h10.
- Redirect to 32'h3C in the same cycle as an ack for addr 8 -> word from 8 is discarded; next `dec_pc`=32'h3C, followed by 32'h40.
- PC at 32'hFFFF_FFFC -> next `imem_addr`=0.
- With `IFETCH_ALIGN_CHECK_EN`, redirect to 32'h22 -> `fetch_err`=1, `dec_valid`=0, `imem_req` stays 0 until reset. Without the macro, the same redirect fetches from 32'h20.
